axis_32to64: RTL and testbench
==============================

Name: axis_32to64

Overview:
- Downstream stage of the 8-to-32 byte packer in the UDP receive path, in the clk_32 domain.
- Packs 32-bit AXI-Stream words (tkeep, tlast) into 64-bit words for the SRIO-side datapath.
- Measures each frame's byte count and flags illegal tkeep patterns.
- Single clock; no CDC; no FIFO. One 64-bit output register plus one 32-bit holding register.

Parameters:
LEN_W, 16, width of frame byte counter and frame_len output.

Ports:
clk  in  1  clock (clk_32 domain).
reset  in  1  asynchronous, active-high reset.
s_axis_tdata  in  32  input word; first-arriving byte of a full word in [31:24].
s_axis_tkeep  in  4  byte enables; legal: 4'b1111 any word; 4'b0001/0011/0111 only with tlast.
s_axis_tvalid  in  1  input valid.
s_axis_tlast  in  1  last word of frame.
s_axis_tready  out  1  input ready.
m_axis_tdata  out  64  packed word.
m_axis_tkeep  out  8  packed byte enables.
m_axis_tvalid  out  1  output valid.
m_axis_tlast  out  1  last word of frame.
m_axis_tready  in  1  downstream ready.
frame_len  out  LEN_W  byte count of the most recently completed frame.
frame_len_valid  out  1  one-cycle pulse when frame_len updates.
err_keep  out  1  one-cycle pulse on an accepted word with an illegal tkeep.

Behaviour:
- Reset (async assert, sync release): all outputs 0. State = LOW_EMPTY. Holding register, counter and output register cleared.
- Accept = s_axis_tvalid & s_axis_tready.
- s_axis_tready = ~m_axis_tvalid | m_axis_tready. Combinational; no dependence on s_axis_tvalid.
- State LOW_EMPTY (no high half held), on accept:
  - tlast=0: store tdata/tkeep in holding register; go to HIGH_HELD; no output.
  - tlast=1: emit {tdata, 32'h0}, keep {tkeep, 4'b0000}, last=1; stay in LOW_EMPTY.
- State HIGH_HELD, on accept:
  - emit {held, tdata}, keep {held_keep, tkeep}, last=tlast.
  - Go to LOW_EMPTY.
- Byte lanes are not realigned. A partial input word keeps its LSB-justified lanes inside its 32-bit half.
- Emit means the output register loads at the clock edge and m_axis_tvalid=1 next cycle. Latency:
  - 1 cycle from the accept of the second word, or of a lone last word.
  - An odd non-last word produces no output until its partner arrives.
- m_axis_tvalid clears when m_axis_tready=1 and no new emit occurs that cycle.
- Output fields are held stable while m_axis_tvalid=1 and m_axis_tready=0 (AXIS-compliant).
- Back-to-back frames: a full 64-bit word out on every second accepted input word when m_axis_tready=1 continuously. Simultaneous drain and load in one cycle gives no bubble.
- Frame counter:
  - Adds popcount(tkeep) on every accept.
  - On an accept with tlast: frame_len <= count + popcount(tkeep); frame_len_valid pulses in the same cycle the last output word loads; counter clears.
  - Saturates at 2^LEN_W-1 and does not wrap.
- err_keep pulses the cycle after an accept with any of:
  - tkeep=4'b0000;
  - tkeep non-contiguous or not LSB-justified (e.g. 4'b1000, 4'b0101);
  - tkeep≠4'b1111 with tlast=0.
  - The word is still forwarded unchanged and counted by popcount.
- tkeep=4'b0000 with tlast in LOW_EMPTY: emit a word with keep 8'h00, last=1; frame_len excludes it (popcount 0).
- Reset mid-frame: held half and partial count are discarded. The first accepted word after reset starts a new frame in LOW_EMPTY.
- s_axis_tvalid low in HIGH_HELD: the held word is kept indefinitely; no timeout.

Test Plan:
- 8-byte frame (0x00010203, 0x04050607 keep F/F last on 2nd) -> one output 0x0001020304050607, keep 0xFF, last=1; frame_len=8 with pulse.
- 5-byte frame (0x0A0B0C0D keep F; 0x0000000E keep 1 last) -> 0x0A0B0C0D0000000E, keep 0xF1, last=1; frame_len=5.
- 3-word frame (keep F, F, 3 last) -> two outputs: keep 0xFF last=0, then {w2,0} keep 0x30 last=1; frame_len=10.
- m_axis_tready held low 5 cycles during a 16-byte frame -> s_axis_tready drops, output word stable, no data loss; exact order recovered after release.
- Illegal keep 4'b0101 on non-last word -> err_keep single pulse, data forwarded, frame_len includes 2 bytes.
- Reset asserted while HIGH_HELD -> outputs 0 immediately; next 4-byte single-word last frame gives keep 0xF0, frame_len=4.

Source files
------------

// File: rtl/axis_32to64_if.sv
// AXI-Stream bundle used on both sides of the 32-to-64 packer.
interface axis_32to64_if #(
  parameter int DW = 32,
  parameter int KW = 4
) ();
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_32to64.sv
// Packs 32-bit AXI-Stream words into 64-bit words, measures frame byte
// counts and flags illegal tkeep patterns. One holding register for the
// high half, one output register; no FIFO.
//
// state      | meaning
// LOW_EMPTY  | no high half held; next word starts a 64-bit output word
// HIGH_HELD  | high half captured, waiting for its low-half partner
module axis_32to64 #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  axis_32to64_if.slave     s_axis,
  axis_32to64_if.master    m_axis,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_len_valid,
  output logic             err_keep
);

  typedef enum logic {LOW_EMPTY, HIGH_HELD} state_t;

  state_t            state_q, state_d;
  logic [31:0]       held_data_q, held_data_d;
  logic [3:0]        held_keep_q, held_keep_d;
  logic [63:0]       m_data_q, m_data_d;
  logic [7:0]        m_keep_q, m_keep_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  frame_len_q, frame_len_d;
  logic              frame_len_valid_q, frame_len_valid_d;
  logic              err_keep_q, err_keep_d;

  logic              s_ready;
  logic              accept;
  logic [2:0]        pop;
  logic [LEN_W:0]    sum_wide;
  logic [LEN_W-1:0]  cnt_sat;
  logic              keep_legal;

  // Ready only depends on the output register being free or draining.
  assign s_ready = ~m_valid_q | m_axis.tready;
  assign accept  = s_axis.tvalid & s_ready;

  // Byte count of the incoming word and the saturating running total.
  always_comb begin
    pop = 3'd0;
    for (int i = 0; i < 4; i++) begin
      pop = pop + {2'b00, s_axis.tkeep[i]};
    end
    sum_wide = {1'b0, cnt_q} + (LEN_W+1)'(pop);
    cnt_sat  = sum_wide[LEN_W] ? '1 : sum_wide[LEN_W-1:0];
    keep_legal = (s_axis.tkeep == 4'b1111) ||
                 (s_axis.tlast && ((s_axis.tkeep == 4'b0001) ||
                                   (s_axis.tkeep == 4'b0011) ||
                                   (s_axis.tkeep == 4'b0111)));
  end

  // Next-state, packing and frame accounting.
  always_comb begin
    state_d           = state_q;
    held_data_d       = held_data_q;
    held_keep_d       = held_keep_q;
    m_data_d          = m_data_q;
    m_keep_d          = m_keep_q;
    m_last_d          = m_last_q;
    m_valid_d         = m_valid_q;
    cnt_d             = cnt_q;
    frame_len_d       = frame_len_q;
    frame_len_valid_d = 1'b0;
    err_keep_d        = 1'b0;

    if (m_valid_q && m_axis.tready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      err_keep_d = ~keep_legal;
      case (state_q)
        LOW_EMPTY: begin
          if (s_axis.tlast) begin
            m_data_d  = {s_axis.tdata, 32'h0};
            m_keep_d  = {s_axis.tkeep, 4'b0000};
            m_last_d  = 1'b1;
            m_valid_d = 1'b1;
          end else begin
            held_data_d = s_axis.tdata;
            held_keep_d = s_axis.tkeep;
            state_d     = HIGH_HELD;
          end
        end
        HIGH_HELD: begin
          m_data_d  = {held_data_q, s_axis.tdata};
          m_keep_d  = {held_keep_q, s_axis.tkeep};
          m_last_d  = s_axis.tlast;
          m_valid_d = 1'b1;
          state_d   = LOW_EMPTY;
        end
        default: state_d = LOW_EMPTY;
      endcase

      if (s_axis.tlast) begin
        frame_len_d       = cnt_sat;
        frame_len_valid_d = 1'b1;
        cnt_d             = '0;
      end else begin
        cnt_d = cnt_sat;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= LOW_EMPTY;
      held_data_q       <= '0;
      held_keep_q       <= '0;
      m_data_q          <= '0;
      m_keep_q          <= '0;
      m_last_q          <= 1'b0;
      m_valid_q         <= 1'b0;
      cnt_q             <= '0;
      frame_len_q       <= '0;
      frame_len_valid_q <= 1'b0;
      err_keep_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      held_data_q       <= held_data_d;
      held_keep_q       <= held_keep_d;
      m_data_q          <= m_data_d;
      m_keep_q          <= m_keep_d;
      m_last_q          <= m_last_d;
      m_valid_q         <= m_valid_d;
      cnt_q             <= cnt_d;
      frame_len_q       <= frame_len_d;
      frame_len_valid_q <= frame_len_valid_d;
      err_keep_q        <= err_keep_d;
    end
  end

  assign s_axis.tready   = s_ready;
  assign m_axis.tdata    = m_data_q;
  assign m_axis.tkeep    = m_keep_q;
  assign m_axis.tvalid   = m_valid_q;
  assign m_axis.tlast    = m_last_q;
  assign frame_len       = frame_len_q;
  assign frame_len_valid = frame_len_valid_q;
  assign err_keep        = err_keep_q;

endmodule

// File: tb/tb_axis_32to64.sv
// Directed bench for the 32-to-64 AXI-Stream packer.
module tb_axis_32to64;

  logic        clk;
  logic        reset;
  logic [15:0] frame_len;
  logic        frame_len_valid;
  logic        err_keep;

  axis_32to64_if #(.DW(32), .KW(4)) s_if ();
  axis_32to64_if #(.DW(64), .KW(8)) m_if ();

  axis_32to64 #(.LEN_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .frame_len       (frame_len),
    .frame_len_valid (frame_len_valid),
    .err_keep        (err_keep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        ov;
    logic [63:0] od;
    logic [7:0]  ok;
    logic        ol;
    logic        flv;
    logic [15:0] len;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] d, logic [3:0] k, logic l, logic ov,
                              logic [63:0] od, logic [7:0] ok, logic ol,
                              logic flv, logic [15:0] len, logic err);
    vec_t v;
    v.d = d; v.k = k; v.l = l; v.ov = ov; v.od = od; v.ok = ok; v.ol = ol;
    v.flv = flv; v.len = len; v.err = err;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
  endtask

  initial begin
    // 8-byte frame
    vecs.push_back(mk(32'h00010203, 4'hF, 0, 0, 64'h0, 8'h00, 0, 0, 16'd0, 0));
    vecs.push_back(mk(32'h04050607, 4'hF, 1, 1, 64'h0001020304050607, 8'hFF, 1, 1, 16'd8, 0));
    // 5-byte frame
    vecs.push_back(mk(32'h0A0B0C0D, 4'hF, 0, 0, 64'h0, 8'h00, 0, 0, 16'd0, 0));
    vecs.push_back(mk(32'h0000000E, 4'h1, 1, 1, 64'h0A0B0C0D0000000E, 8'hF1, 1, 1, 16'd5, 0));
    // 3-word, 10-byte frame
    vecs.push_back(mk(32'h11223344, 4'hF, 0, 0, 64'h0, 8'h00, 0, 0, 16'd0, 0));
    vecs.push_back(mk(32'h55667788, 4'hF, 0, 1, 64'h1122334455667788, 8'hFF, 0, 0, 16'd0, 0));
    vecs.push_back(mk(32'h0000AABB, 4'h3, 1, 1, 64'h0000AABB00000000, 8'h30, 1, 1, 16'd10, 0));
    // Illegal 0101 on a non-last word
    vecs.push_back(mk(32'hDEADBEEF, 4'h5, 0, 0, 64'h0, 8'h00, 0, 0, 16'd0, 1));
    vecs.push_back(mk(32'hCAFEF00D, 4'hF, 1, 1, 64'hDEADBEEFCAFEF00D, 8'h5F, 1, 1, 16'd6, 0));
    // Empty keep with last in LOW_EMPTY
    vecs.push_back(mk(32'h12345678, 4'h0, 1, 1, 64'h1234567800000000, 8'h00, 1, 1, 16'd0, 1));
    // Lone 4-byte word, back-to-back with previous output
    vecs.push_back(mk(32'hA1B2C3D4, 4'hF, 1, 1, 64'hA1B2C3D400000000, 8'hF0, 1, 1, 16'd4, 0));
    // Partial keep on a non-last low half, then a lone last word
    vecs.push_back(mk(32'h01020304, 4'hF, 0, 0, 64'h0, 8'h00, 0, 0, 16'd0, 0));
    vecs.push_back(mk(32'h05060708, 4'h7, 0, 1, 64'h0102030405060708, 8'hF7, 0, 0, 16'd0, 1));
    vecs.push_back(mk(32'h090A0B0C, 4'hF, 1, 1, 64'h090A0B0C00000000, 8'hF0, 1, 1, 16'd11, 0));
    // Not LSB-justified keep with last
    vecs.push_back(mk(32'h11111111, 4'h8, 1, 1, 64'h1111111100000000, 8'h80, 1, 1, 16'd1, 1));

    reset       = 1'b1;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) tick();
    chk("rst_m_valid", 64'(m_if.tvalid), 64'h0);
    chk("rst_m_data", m_if.tdata, 64'h0);
    chk("rst_frame_len", 64'(frame_len), 64'h0);
    chk("rst_flv", 64'(frame_len_valid), 64'h0);
    chk("rst_err", 64'(err_keep), 64'h0);
    reset = 1'b0;
    tick();
    chk("rst_s_ready", 64'(s_if.tready), 64'h1);

    // Table-driven vectors, continuous ready
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].d, vecs[i].k, vecs[i].l);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(m_if.tvalid), 64'(vecs[i].ov));
      if (vecs[i].ov) begin
        chk($sformatf("v%0d_data", i), m_if.tdata, vecs[i].od);
        chk($sformatf("v%0d_keep", i), 64'(m_if.tkeep), 64'(vecs[i].ok));
        chk($sformatf("v%0d_last", i), 64'(m_if.tlast), 64'(vecs[i].ol));
      end
      chk($sformatf("v%0d_flv", i), 64'(frame_len_valid), 64'(vecs[i].flv));
      if (vecs[i].flv) chk($sformatf("v%0d_len", i), 64'(frame_len), 64'(vecs[i].len));
      chk($sformatf("v%0d_err", i), 64'(err_keep), 64'(vecs[i].err));
    end
    s_if.tvalid = 1'b0;
    tick();
    chk("drain_valid", 64'(m_if.tvalid), 64'h0);

    // Held high half survives an idle input
    drive(32'h5A5A5A5A, 4'hF, 1'b0);
    tick();
    s_if.tvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("idle_held_valid", 64'(m_if.tvalid), 64'h0);
    end
    drive(32'hA5A5A5A5, 4'h1, 1'b1);
    tick();
    s_if.tvalid = 1'b0;
    chk("idle_data", m_if.tdata, 64'h5A5A5A5AA5A5A5A5);
    chk("idle_keep", 64'(m_if.tkeep), 64'hF1);
    chk("idle_len", 64'(frame_len), 64'd5);
    tick();

    // Backpressure during a 16-byte frame
    m_if.tready = 1'b0;
    drive(32'h00112233, 4'hF, 1'b0);
    tick();
    drive(32'h44556677, 4'hF, 1'b0);
    tick();
    chk("bp_valid0", 64'(m_if.tvalid), 64'h1);
    chk("bp_sready_low", 64'(s_if.tready), 64'h0);
    drive(32'h8899AABB, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stall_valid", 64'(m_if.tvalid), 64'h1);
      chk("bp_stall_data", m_if.tdata, 64'h0011223344556677);
      chk("bp_stall_last", 64'(m_if.tlast), 64'h0);
      chk("bp_stall_sready", 64'(s_if.tready), 64'h0);
    end
    m_if.tready = 1'b1;
    #1;
    chk("bp_sready_rel", 64'(s_if.tready), 64'h1);
    tick();
    chk("bp_after_drain", 64'(m_if.tvalid), 64'h0);
    drive(32'hCCDDEEFF, 4'hF, 1'b1);
    tick();
    s_if.tvalid = 1'b0;
    chk("bp_w1_valid", 64'(m_if.tvalid), 64'h1);
    chk("bp_w1_data", m_if.tdata, 64'h8899AABBCCDDEEFF);
    chk("bp_w1_last", 64'(m_if.tlast), 64'h1);
    chk("bp_len", 64'(frame_len), 64'd16);
    chk("bp_flv", 64'(frame_len_valid), 64'h1);
    tick();

    // Counter saturation: 16385 full words = 65540 bytes
    for (int i = 0; i < 16384; i++) begin
      drive(i[31:0], 4'hF, 1'b0);
      tick();
    end
    drive(32'hFFFFFFFF, 4'hF, 1'b1);
    tick();
    s_if.tvalid = 1'b0;
    chk("sat_flv", 64'(frame_len_valid), 64'h1);
    chk("sat_len", 64'(frame_len), 64'hFFFF);
    tick();

    // Reset while a high half is held
    drive(32'h99887766, 4'h3, 1'b0);
    tick();
    s_if.tvalid = 1'b0;
    chk("mid_err", 64'(err_keep), 64'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_err", 64'(err_keep), 64'h0);
    chk("mid_rst_len", 64'(frame_len), 64'h0);
    chk("mid_rst_valid", 64'(m_if.tvalid), 64'h0);
    tick();
    reset = 1'b0;
    drive(32'hC0C1C2C3, 4'hF, 1'b1);
    tick();
    s_if.tvalid = 1'b0;
    chk("post_rst_valid", 64'(m_if.tvalid), 64'h1);
    chk("post_rst_data", m_if.tdata, 64'hC0C1C2C300000000);
    chk("post_rst_keep", 64'(m_if.tkeep), 64'hF0);
    chk("post_rst_len", 64'(frame_len), 64'd4);
    chk("post_rst_flv", 64'(frame_len_valid), 64'h1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
